// File: rtl/servo_pkg.sv
// Shared servo timing defaults and counter-sizing helpers; reused by the PWM array and the steering controller.
package servo_pkg;

    localparam int DEF_N_CH         = 3;
    localparam int DEF_CMD_W        = 10;
    localparam int DEF_TICK_CYCLES  = 1000;
    localparam int DEF_FRAME_TICKS  = 2000;
    localparam int DEF_MIN_TICKS    = 100;
    localparam int DEF_MAX_TICKS    = 200;
    localparam int DEF_CENTER_TICKS = 150;
    localparam int DEF_SLEW_STEP    = 5;

    function automatic int ch_idx_w(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

    function automatic int cnt_w(input int modulus);
        return (modulus <= 1) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: target/active position, per-frame slew toward target, frame-aligned pulse output.
module servo_slew_channel
    import servo_pkg::*;
#(
    parameter int CMD_W        = DEF_CMD_W,
    parameter int FR_W         = 11,
    parameter int CENTER_TICKS = DEF_CENTER_TICKS,
    parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic             wr_en,
    input  logic [CMD_W-1:0] wr_pos,
    input  logic             ch_en,
    input  logic [FR_W-1:0]  frame_cnt,
    output logic             pwm,
    output logic             settled
);

    localparam logic [CMD_W-1:0] STEP   = CMD_W'(SLEW_STEP);
    localparam logic [CMD_W-1:0] CENTER = CMD_W'(CENTER_TICKS);

    logic [CMD_W-1:0] target_q, target_d;
    logic [CMD_W-1:0] active_q, active_d;
    logic             en_q, en_d;
    logic             pwm_q, pwm_d;
    logic             settled_q, settled_d;

    // The boundary update reads target_q, so a write landing in the boundary cycle waits one frame.
    always_comb begin
        target_d  = target_q;
        active_d  = active_q;
        en_d      = en_q;
        if (wr_en) begin
            target_d = wr_pos;
        end
        if (boundary) begin
            en_d = ch_en;
            if (SLEW_STEP == 0) begin
                active_d = target_q;
            end else if (target_q > active_q) begin
                if ((target_q - active_q) > STEP) begin
                    active_d = active_q + STEP;
                end else begin
                    active_d = target_q;
                end
            end else begin
                if ((active_q - target_q) > STEP) begin
                    active_d = active_q - STEP;
                end else begin
                    active_d = target_q;
                end
            end
        end
        settled_d = (active_d == target_d);
        pwm_d     = en_q && (32'(frame_cnt) < 32'(active_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q  <= CENTER;
            active_q  <= CENTER;
            en_q      <= 1'b0;
            pwm_q     <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            target_q  <= target_d;
            active_q  <= active_d;
            en_q      <= en_d;
            pwm_q     <= pwm_d;
            settled_q <= settled_d;
        end
    end

    assign pwm     = pwm_q;
    assign settled = settled_q;

endmodule

// File: rtl/servo_pwm_array.sv
// N-channel hobby-servo PWM generator: shared tick/frame timebase, clamped command port, per-channel slew stages.
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int CMD_W        = DEF_CMD_W,
    parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
    parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
    parameter int MIN_TICKS    = DEF_MIN_TICKS,
    parameter int MAX_TICKS    = DEF_MAX_TICKS,
    parameter int CENTER_TICKS = DEF_CENTER_TICKS,
    parameter int SLEW_STEP    = DEF_SLEW_STEP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ch_idx_w(N_CH)-1:0] cmd_ch,
    input  logic [CMD_W-1:0]          cmd_pos,
    output logic                      cmd_err,
    input  logic [N_CH-1:0]           ch_en,
    output logic [N_CH-1:0]           pwm,
    output logic [N_CH-1:0]           settled,
    output logic                      frame_start
);

    localparam int PRE_W = cnt_w(TICK_CYCLES);
    localparam int FR_W  = cnt_w(FRAME_TICKS);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(FRAME_TICKS - 1);
    localparam logic [CMD_W-1:0] POS_MIN  = CMD_W'(MIN_TICKS);
    localparam logic [CMD_W-1:0] POS_MAX  = CMD_W'(MAX_TICKS);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [FR_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             frame_start_q, frame_start_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             cmd_err_q, cmd_err_d;

    logic             tick;
    logic             boundary;
    logic             accept;
    logic             idx_ok;
    logic [CMD_W-1:0] pos_clamped;
    logic [N_CH-1:0]  wr_en;

    always_comb begin
        tick          = (presc_q == PRE_LAST);
        boundary      = tick && (frame_cnt_q == FR_LAST);
        presc_d       = tick ? '0 : presc_q + 1'b1;
        frame_cnt_d   = frame_cnt_q;
        if (tick) begin
            frame_cnt_d = (frame_cnt_q == FR_LAST) ? '0 : frame_cnt_q + 1'b1;
        end
        frame_start_d = boundary;
    end

    // cmd_ready only guards the reset window; after that every write is taken.
    always_comb begin
        cmd_ready_d = 1'b1;
        accept      = cmd_valid && cmd_ready_q;
        idx_ok      = (32'(cmd_ch) < 32'(N_CH));
        cmd_err_d   = accept && !idx_ok;
        if (cmd_pos < POS_MIN) begin
            pos_clamped = POS_MIN;
        end else if (cmd_pos > POS_MAX) begin
            pos_clamped = POS_MAX;
        end else begin
            pos_clamped = cmd_pos;
        end
        wr_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (accept && (32'(cmd_ch) == 32'(i))) begin
                wr_en[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            cmd_ready_q   <= cmd_ready_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        servo_slew_channel #(
            .CMD_W        (CMD_W),
            .FR_W         (FR_W),
            .CENTER_TICKS (CENTER_TICKS),
            .SLEW_STEP    (SLEW_STEP)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .boundary  (boundary),
            .wr_en     (wr_en[g]),
            .wr_pos    (pos_clamped),
            .ch_en     (ch_en[g]),
            .frame_cnt (frame_cnt_q),
            .pwm       (pwm[g]),
            .settled   (settled[g])
        );
    end

    assign cmd_ready   = cmd_ready_q;
    assign cmd_err     = cmd_err_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Self-checking bench for servo_pwm_array: arithmetic timebase reference model plus targeted pulse-width sequences.
module tb_servo_pwm_array;

    localparam int N_CH      = 3;
    localparam int CMD_W     = 10;
    localparam int TICK      = 4;
    localparam int FRAME     = 40;
    localparam int MINT      = 10;
    localparam int MAXT      = 20;
    localparam int CTR       = 15;
    localparam int SLEW      = 2;
    localparam int FRAME_CLK = TICK * FRAME;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_ch = '0;
    logic [CMD_W-1:0] cmd_pos = '0;
    logic [N_CH-1:0]  ch_en = 3'b111;
    logic             cmd_ready, cmd_err, frame_start;
    logic [N_CH-1:0]  pwm, settled;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    servo_pwm_array #(
        .N_CH(N_CH), .CMD_W(CMD_W), .TICK_CYCLES(TICK), .FRAME_TICKS(FRAME),
        .MIN_TICKS(MINT), .MAX_TICKS(MAXT), .CENTER_TICKS(CTR), .SLEW_STEP(SLEW)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .cmd_err(cmd_err), .ch_en(ch_en),
        .pwm(pwm), .settled(settled), .frame_start(frame_start)
    );

    // Reference model: time since reset release gives tick/frame position arithmetically.
    int              m_t;
    int              m_tgt[N_CH];
    int              m_act[N_CH];
    logic [N_CH-1:0] m_en, m_pwm, m_settled;
    logic            m_fs, m_err, m_ready;
    bit              m_valid = 0;

    function automatic int clampPos(input int p);
        if (p < MINT) return MINT;
        if (p > MAXT) return MAXT;
        return p;
    endfunction

    always @(posedge clk) begin
        int  fc;
        int  d;
        bit  bnd;
        bit  acc;
        if (rst) begin
            m_t = 0;
            for (int i = 0; i < N_CH; i++) begin
                m_tgt[i] = CTR;
                m_act[i] = CTR;
            end
            m_en = '0; m_pwm = '0; m_settled = '1;
            m_fs = 0; m_err = 0; m_ready = 0;
            m_valid = 1;
        end else if (m_valid) begin
            acc = cmd_valid && m_ready;
            fc  = (m_t / TICK) % FRAME;
            bnd = (m_t % FRAME_CLK) == FRAME_CLK - 1;
            for (int i = 0; i < N_CH; i++) m_pwm[i] = m_en[i] && (fc < m_act[i]);
            m_fs = bnd;
            if (bnd) begin
                for (int i = 0; i < N_CH; i++) begin
                    m_en[i] = ch_en[i];
                    d = m_tgt[i] - m_act[i];
                    if (d > SLEW) d = SLEW;
                    if (d < -SLEW) d = -SLEW;
                    m_act[i] = m_act[i] + d;
                end
            end
            m_err = acc && (int'(cmd_ch) >= N_CH);
            if (acc && int'(cmd_ch) < N_CH) m_tgt[cmd_ch] = clampPos(int'(cmd_pos));
            for (int i = 0; i < N_CH; i++) m_settled[i] = (m_act[i] == m_tgt[i]);
            m_ready = 1;
            m_t = m_t + 1;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        logic [9:0] act_v, exp_v;
        if (m_valid) begin
            act_v = {cmd_ready, cmd_err, frame_start, settled, pwm};
            exp_v = {m_ready, m_err, m_fs, m_settled, m_pwm};
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("[TB] FAIL model_cycle: {rdy,err,fs,settled,pwm} got %b, expected %b (m_t=%0d)",
                         act_v, exp_v, m_t);
            end
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [1:0] ch, input int pos);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_pos   = CMD_W'(pos);
        stepCycle();
        cmd_valid = 1'b0;
    endtask

    task automatic countToFrameStart(output int n);
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (!frame_start && n < 400);
        if (!frame_start) check("frame_start_timeout", 0, 1);
    endtask

    task automatic measureFrame(output int w0, output int w1, output int w2);
        int n;
        n = 0;
        w0 = 0; w1 = 0; w2 = 0;
        while (!frame_start && n < 400) begin
            stepCycle();
            n++;
        end
        if (!frame_start) check("measure_sync_timeout", 0, 1);
        for (int k = 0; k < FRAME_CLK; k++) begin
            w0 += int'(pwm[0]);
            w1 += int'(pwm[1]);
            w2 += int'(pwm[2]);
            if (k < FRAME_CLK - 1) stepCycle();
        end
    endtask

    typedef struct {
        logic [1:0] ch;
        int         pos;
        logic       exp_err;
        logic [2:0] exp_settled;
    } vec_t;

    initial begin
        vec_t tbl[10];
        int   n, w0, w1, w2, acc2;
        int   exp_ch1[4];
        int   exp_ch0[3];
        int   exp_ch2[3];

        tbl[0] = '{2'd0, 15,   1'b0, 3'b111};
        tbl[1] = '{2'd0, 5,    1'b0, 3'b110};
        tbl[2] = '{2'd3, 12,   1'b1, 3'b110};
        tbl[3] = '{2'd2, 1023, 1'b0, 3'b010};
        tbl[4] = '{2'd0, 15,   1'b0, 3'b011};
        tbl[5] = '{2'd2, 150,  1'b0, 3'b011};
        tbl[6] = '{2'd2, 15,   1'b0, 3'b111};
        tbl[7] = '{2'd1, 9,    1'b0, 3'b101};
        tbl[8] = '{2'd1, 21,   1'b0, 3'b101};
        tbl[9] = '{2'd1, 15,   1'b0, 3'b111};
        exp_ch1 = '{68, 76, 80, 80};
        exp_ch0 = '{52, 44, 40};
        exp_ch2 = '{68, 76, 80};

        // Reset values
        repeat (3) stepCycle();
        check("reset_pwm", int'(pwm), 0);
        check("reset_settled", int'(settled), 7);
        check("reset_ready", int'(cmd_ready), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_cmd_err", int'(cmd_err), 0);
        rst = 1'b0;
        stepCycle();
        check("ready_after_release", int'(cmd_ready), 1);

        // Clamp / index / settled vectors, all within the first frame
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].ch, tbl[i].pos);
            check($sformatf("vec%0d_cmd_err", i), int'(cmd_err), int'(tbl[i].exp_err));
            check($sformatf("vec%0d_settled", i), int'(settled), int'(tbl[i].exp_settled));
        end

        // Frame period and centred pulses
        countToFrameStart(n);
        countToFrameStart(n);
        check("frame_period", n, FRAME_CLK);

        // ch1 slews up to 20
        applyStimulus(2'd1, 20);
        for (int f = 0; f < 4; f++) begin
            measureFrame(w0, w1, w2);
            check($sformatf("slew_up_ch1_f%0d", f), w1, exp_ch1[f]);
            check($sformatf("slew_up_ch0_f%0d", f), w0, 60);
        end

        // ch0 clamped low, ch2 clamped high
        repeat (5) stepCycle();
        applyStimulus(2'd0, 5);
        applyStimulus(2'd2, 1023);
        for (int f = 0; f < 3; f++) begin
            measureFrame(w0, w1, w2);
            check($sformatf("clamp_ch0_f%0d", f), w0, exp_ch0[f]);
            check($sformatf("clamp_ch2_f%0d", f), w2, exp_ch2[f]);
        end

        // Write in boundary cycle plus ch_en[2] cleared mid-pulse
        countToFrameStart(n);
        acc2 = 0;
        for (int k = 0; k < FRAME_CLK; k++) begin
            acc2 += int'(pwm[2]);
            if (k == 20) ch_en = 3'b011;
            if (k < FRAME_CLK - 1) stepCycle();
            else applyStimulus(2'd1, 10);
        end
        check("en_clear_pulse_completes", acc2, 80);
        measureFrame(w0, w1, w2);
        check("bwrite_ch1_old_target", w1, 80);
        check("en_clear_ch2_low", w2, 0);
        measureFrame(w0, w1, w2);
        check("bwrite_ch1_step", w1, 72);
        check("en_clear_ch2_low_2", w2, 0);

        // Randomised traffic against the model
        ch_en = 3'b111;
        for (int c = 0; c < 1600; c++) begin
            if (c % 200 == 0) ch_en = 3'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 0) applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 30));
                else applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 1023));
            end else begin
                stepCycle();
            end
        end

        // Reset mid-pulse
        ch_en = 3'b111;
        countToFrameStart(n);
        repeat (10) stepCycle();
        rst = 1'b1;
        stepCycle();
        check("pwm_drop_on_reset", int'(pwm), 0);
        repeat (2) stepCycle();
        check("settled_after_reset", int'(settled), 7);
        rst = 1'b0;
        countToFrameStart(n);
        check("first_frame_after_reset", n, FRAME_CLK);
        measureFrame(w0, w1, w2);
        check("post_reset_ch0", w0, 60);
        check("post_reset_ch1", w1, 60);
        check("post_reset_ch2", w2, 60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
